// File: rtl/cbuf_arb_pkg.sv
// Shared definitions for the circular-buffer write arbiter: FSM state
// encoding, default parameter values and the burst-counter width.
package cbuf_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_SRC_W     = 2;
   localparam int DEF_PAYLOAD_W = 8;
   localparam int DEF_MAX_BURST = 4;

   // Wide enough for MAX_BURST up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// last_grant+1, wrapping around, plus a flag that any request is present.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last_grant,
   output logic [W-1:0] o_sel,
   output logic         o_any
);

   logic [31:0] w_idx;

   // Scan N positions starting just after the last winner; first hit wins.
   always_comb begin
      o_sel = '0;
      o_any = 1'b0;
      w_idx = '0;
      for (int i = 1; i <= N; i++) begin
         w_idx = 32'((int'(i_last_grant) + i) % N);
         if (!o_any && i_req[w_idx[W-1:0]]) begin
            o_any = 1'b1;
            o_sel = w_idx[W-1:0];
         end
      end
   end

endmodule

// File: rtl/cbuf_write_arbiter.sv
// Round-robin, burst-locking arbiter for the write side of a circular buffer.
// Each accepted beat is written as {source id, payload}.
// Optional per-producer grant statistics: define ARB_STATS_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no lock held; round-robin pick, first beat accepted here
//   ST_BURST | locked to owner until last beat or MAX_BURST beats written
module cbuf_write_arbiter
   import cbuf_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int SRC_W     = DEF_SRC_W,
   parameter int PAYLOAD_W = DEF_PAYLOAD_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         buf_full,
   output logic                         buf_write_en,
   output logic [SRC_W+PAYLOAD_W-1:0]   buf_data_in,
   output logic [SRC_W-1:0]             owner,
   output logic                         busy,
   output logic                         burst_trunc
`ifdef ARB_STATS_EN
   ,
   input  logic [SRC_W-1:0]             stat_sel,
   output logic [15:0]                  stat_count
`endif
);

   arb_state_t         r_state, w_state_nxt;
   logic [SRC_W-1:0]   r_owner, w_owner_nxt;
   logic [SRC_W-1:0]   r_last_grant, w_last_nxt;
   logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;
   logic               r_burst_trunc, w_trunc_nxt;

   logic [SRC_W-1:0]   w_sel;
   logic               w_any;
   logic [SRC_W-1:0]   w_src;
   logic [NUM_REQ-1:0] w_src_oh;
   logic [PAYLOAD_W-1:0] w_payload;
   logic               w_src_last;
   logic               w_can_go;

   rr_pick #(
      .N (NUM_REQ),
      .W (SRC_W)
   ) u_rr_pick (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_sel        (w_sel),
      .o_any        (w_any)
   );

   // Datapath: pick the source (winner in IDLE, owner in BURST) and gate the
   // handshake with buf_full and rst so nothing is ever written into a full buffer.
   always_comb begin
      w_src      = (r_state == ST_IDLE) ? w_sel : r_owner;
      w_src_oh   = '0;
      w_payload  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_src == SRC_W'(i)) begin
            w_src_oh[i] = 1'b1;
            w_payload   = req_data[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
      w_src_last = |(req_last & w_src_oh);
      w_can_go   = !rst && !buf_full &&
                   ((r_state == ST_IDLE) ? w_any : |(req_valid & w_src_oh));
      req_ready  = (!rst && !buf_full && (r_state == ST_BURST || w_any)) ? w_src_oh : '0;
      buf_write_en = w_can_go;
      buf_data_in  = w_can_go ? {w_src, w_payload} : '0;
   end

   // Next-state logic: lock on first beat, release on last beat or at MAX_BURST.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_grant;
      w_cnt_nxt   = r_beat_cnt;
      w_trunc_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_can_go) begin
               w_owner_nxt = w_sel;
               w_cnt_nxt   = CNT_W'(1);
               if (w_src_last || MAX_BURST == 1) begin
                  w_last_nxt  = w_sel;
                  w_trunc_nxt = !w_src_last;
               end else begin
                  w_state_nxt = ST_BURST;
               end
            end
         end
         ST_BURST: begin
            if (w_can_go) begin
               w_cnt_nxt = r_beat_cnt + CNT_W'(1);
               if (w_src_last) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = r_owner;
               end else if (r_beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = r_owner;
                  w_trunc_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and control registers; last_grant resets so producer 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_owner       <= '0;
         r_last_grant  <= SRC_W'(NUM_REQ - 1);
         r_beat_cnt    <= '0;
         r_burst_trunc <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_owner       <= w_owner_nxt;
         r_last_grant  <= w_last_nxt;
         r_beat_cnt    <= w_cnt_nxt;
         r_burst_trunc <= w_trunc_nxt;
      end
   end

   assign owner       = r_owner;
   assign busy        = (r_state == ST_BURST);
   assign burst_trunc = r_burst_trunc;

`ifdef ARB_STATS_EN
   logic        w_burst_start;
   logic [15:0] r_grant_cnt [NUM_REQ];
   logic [15:0] r_stat_count;

   assign w_burst_start = (r_state == ST_IDLE) && w_can_go;

   // Saturating per-producer grant counters, bumped on every burst start.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_burst_start && w_sel == SRC_W'(i) && r_grant_cnt[i] != 16'hFFFF)
               r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
         end
      end
   end

   // Registered readback, one cycle after stat_sel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_count <= '0;
      end else begin
         r_stat_count <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == SRC_W'(i)) r_stat_count <= r_grant_cnt[i];
         end
      end
   end

   assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_cbuf_write_arbiter.sv
// Directed bench for cbuf_write_arbiter (default parameters).
module tb_cbuf_write_arbiter;

   localparam int NR = 4;
   localparam int SW = 2;
   localparam int PW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_last;
   logic [NR*PW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              buf_full;
   logic              buf_write_en;
   logic [SW+PW-1:0]  buf_data_in;
   logic [SW-1:0]     owner;
   logic              busy;
   logic              burst_trunc;
`ifdef ARB_STATS_EN
   logic [SW-1:0]     stat_sel;
   logic [15:0]       stat_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cbuf_write_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .buf_full     (buf_full),
      .buf_write_en (buf_write_en),
      .buf_data_in  (buf_data_in),
      .owner        (owner),
      .busy         (busy),
      .burst_trunc  (burst_trunc)
`ifdef ARB_STATS_EN
      ,
      .stat_sel     (stat_sel),
      .stat_count   (stat_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int p, input logic [7:0] v);
      req_data[p*PW +: PW] = v;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // One cycle: drive inputs, check the combinational handshake, advance.
   task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic we, input int src, input logic [7:0] pay);
      logic [1:0] s;
      s = src[1:0];
      req_valid = v;
      req_last  = l;
      buf_full  = f;
      #1;
      check({tag, "_we"}, buf_write_en, we);
      if (we) begin
         check({tag, "_data"}, buf_data_in, {s, pay});
         check({tag, "_rdy"}, req_ready, 32'd1 << src);
      end else begin
         check({tag, "_rdy"}, req_ready, 32'd0);
      end
      next_edge();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'h0;
      req_data  = '0;
      buf_full  = 1'b0;
`ifdef ARB_STATS_EN
      stat_sel  = '0;
`endif
      for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));

      // Reset: handshake forced low, registers at reset values.
      #1;
      check("rst_we", buf_write_en, 0);
      check("rst_rdy", req_ready, 0);
      check("rst_data", buf_data_in, 0);
      next_edge();
      next_edge();
      check("rst_owner", owner, 0);
      check("rst_busy", busy, 0);
      check("rst_trunc", burst_trunc, 0);
      rst = 1'b0;

      // Single-beat bursts from everyone: strict rotation 0,1,2,3,0.
      cyc("rr0", 4'hF, 4'hF, 1'b0, 1'b1, 0, 8'h10);
      cyc("rr1", 4'hF, 4'hF, 1'b0, 1'b1, 1, 8'h11);
      cyc("rr2", 4'hF, 4'hF, 1'b0, 1'b1, 2, 8'h12);
      cyc("rr3", 4'hF, 4'hF, 1'b0, 1'b1, 3, 8'h13);
      check("rr3_owner", owner, 3);
      check("rr3_busy", busy, 0);
      cyc("rr4", 4'hF, 4'hF, 1'b0, 1'b1, 0, 8'h10);
      // Idle cycles must not move the pointer.
      cyc("idle0", 4'h0, 4'h0, 1'b0, 1'b0, 0, 8'h00);
      cyc("idle1", 4'h0, 4'h0, 1'b0, 1'b0, 0, 8'h00);
      cyc("p1", 4'b0010, 4'b0010, 1'b0, 1'b1, 1, 8'h11);

      // Producer 2 three-beat burst while 1 and 3 wait; last_grant is 1.
      set_data(2, 8'hA1);
      cyc("b2a", 4'b1110, 4'b0000, 1'b0, 1'b1, 2, 8'hA1);
      check("b2a_busy", busy, 1);
      check("b2a_owner", owner, 2);
      req_valid = 4'b1010;
      #1;
      check("b2gap_we", buf_write_en, 0);
      check("b2gap_others", req_ready & 4'b1011, 0);
      next_edge();
      check("b2gap_busy", busy, 1);
      set_data(2, 8'hA2);
      cyc("b2b", 4'b1110, 4'b0000, 1'b0, 1'b1, 2, 8'hA2);
      set_data(2, 8'hA3);
      cyc("b2c", 4'b1110, 4'b0100, 1'b0, 1'b1, 2, 8'hA3);
      check("b2c_busy", busy, 0);
      cyc("b2next", 4'b1010, 4'b1010, 1'b0, 1'b1, 3, 8'h13);

      // Producer 1 six beats without last, truncated at 4; producer 2 served between.
      set_data(2, 8'hC2);
      set_data(1, 8'hB1);
      cyc("t1", 4'b0110, 4'b0100, 1'b0, 1'b1, 1, 8'hB1);
      set_data(1, 8'hB2);
      cyc("t2", 4'b0110, 4'b0100, 1'b0, 1'b1, 1, 8'hB2);
      set_data(1, 8'hB3);
      cyc("t3", 4'b0110, 4'b0100, 1'b0, 1'b1, 1, 8'hB3);
      check("t3_trunc", burst_trunc, 0);
      check("t3_busy", busy, 1);
      set_data(1, 8'hB4);
      cyc("t4", 4'b0110, 4'b0100, 1'b0, 1'b1, 1, 8'hB4);
      check("t4_trunc", burst_trunc, 1);
      check("t4_busy", busy, 0);
      cyc("t5", 4'b0110, 4'b0100, 1'b0, 1'b1, 2, 8'hC2);
      check("t5_trunc", burst_trunc, 0);
      set_data(1, 8'hB5);
      cyc("t6", 4'b0110, 4'b0100, 1'b0, 1'b1, 1, 8'hB5);
      set_data(1, 8'hB6);
      cyc("t7", 4'b0110, 4'b0110, 1'b0, 1'b1, 1, 8'hB6);
      check("t7_busy", busy, 0);
      check("t7_trunc", burst_trunc, 0);

      // Stall mid-burst on buf_full: no ready, no write, lock held.
      set_data(3, 8'hD1);
      cyc("s1", 4'b1000, 4'b0000, 1'b0, 1'b1, 3, 8'hD1);
      set_data(3, 8'hD2);
      for (int k = 0; k < 3; k++) begin
         cyc("stall", 4'b1010, 4'b0000, 1'b1, 1'b0, 0, 8'h00);
         check("stall_busy", busy, 1);
      end
      cyc("s2", 4'b1010, 4'b0000, 1'b0, 1'b1, 3, 8'hD2);
      set_data(3, 8'hD3);
      cyc("s3", 4'b1010, 4'b1000, 1'b0, 1'b1, 3, 8'hD3);
      check("s3_busy", busy, 0);

      // Reset on the second beat of a producer-2 burst.
      set_data(2, 8'hE1);
      cyc("r1", 4'b0100, 4'b0000, 1'b0, 1'b1, 2, 8'hE1);
      check("r1_owner", owner, 2);
      rst = 1'b1;
      set_data(2, 8'hE2);
      #1;
      check("r2_we", buf_write_en, 0);
      check("r2_rdy", req_ready, 0);
      next_edge();
      check("r2_busy", busy, 0);
      check("r2_owner", owner, 0);
      rst = 1'b0;
      cyc("r3", 4'hF, 4'hF, 1'b0, 1'b1, 0, 8'h10);

`ifdef ARB_STATS_EN
      // Five single-beat bursts from producer 3 after the reset.
      set_data(3, 8'h33);
      for (int k = 0; k < 5; k++) cyc("st", 4'b1000, 4'b1000, 1'b0, 1'b1, 3, 8'h33);
      req_valid = '0;
      stat_sel  = 2'd3;
      next_edge();
      check("stat3", stat_count, 5);
      stat_sel = 2'd0;
      next_edge();
      check("stat0", stat_count, 1);
      stat_sel = 2'd2;
      next_edge();
      check("stat2", stat_count, 0);
`endif

      req_valid = '0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
